// File: rtl/mpc_div_sdiv_28s_7s_21_seq.sv
// rtl/mpc_div_sdiv_28s_7s_21_seq.sv - radix-2 restoring signed divider, 28s / 7s -> 21s quotient + 7s remainder
// Optional round-half-away-from-zero is enabled by defining MPC_DIV_ROUND_EN.
module mpc_div_sdiv_28s_7s_21_seq #(
    parameter int din0_WIDTH = 28,
    parameter int din1_WIDTH = 7,
    parameter int dout_WIDTH = 21
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  ready,
    output logic                  dout_vld,
    output logic [dout_WIDTH-1:0] quot,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  ovf,
    output logic                  div_by_zero
);
    localparam int N  = din0_WIDTH;
    localparam int M  = din1_WIDTH;
    localparam int CW = $clog2(N + 1);

    localparam logic [N:0] POS_LIM = (N+1)'((64'd1 << (dout_WIDTH - 1)) - 64'd1);
    localparam logic [N:0] NEG_LIM = (N+1)'(64'd1 << (dout_WIDTH - 1));
    localparam logic [dout_WIDTH-1:0] QMAX = {1'b0, {(dout_WIDTH-1){1'b1}}};
    localparam logic [dout_WIDTH-1:0] QMIN = {1'b1, {(dout_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [N-1:0]          dvd_q, dvd_d;
    logic [M-1:0]          dvs_q, dvs_d;
    logic [M:0]            prem_q, prem_d;
    logic                  qneg_q, qneg_d;
    logic                  dneg_q, dneg_d;
    logic [dout_WIDTH-1:0] quot_q, quot_d;
    logic [M-1:0]          rem_q, rem_d;
    logic                  ovf_q, ovf_d;
    logic                  dbz_q, dbz_d;
    logic                  vld_q, vld_d;

    // dvd_q holds the remaining dividend bits and collects quotient bits from the LSB end
    logic [M+1:0] shifted, trial;
    assign shifted = {prem_q, dvd_q[N-1]};
    assign trial   = shifted - {2'b00, dvs_q};

    logic [N:0] qmag;
    logic [M:0] rmag;
`ifdef MPC_DIV_ROUND_EN
    logic rnd_up;
    assign rnd_up = (dvs_q != '0) && ({prem_q, 1'b0} >= {2'b00, dvs_q});
    assign qmag   = {1'b0, dvd_q} + {{N{1'b0}}, rnd_up};
    assign rmag   = rnd_up ? (prem_q - {1'b0, dvs_q}) : prem_q;
`else
    assign qmag = {1'b0, dvd_q};
    assign rmag = prem_q;
`endif

    logic dz, ovf_hit;
    assign dz      = (dvs_q == '0);
    assign ovf_hit = qneg_q ? (qmag > NEG_LIM) : (qmag > POS_LIM);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        prem_d  = prem_q;
        qneg_d  = qneg_q;
        dneg_d  = dneg_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;
        vld_d   = vld_q;
        if (ce) begin
            case (state_q)
                IDLE: begin
                    vld_d = 1'b0;
                    if (start) begin
                        dvd_d   = din0[N-1] ? -din0 : din0;
                        dvs_d   = din1[M-1] ? -din1 : din1;
                        prem_d  = '0;
                        qneg_d  = din0[N-1] ^ din1[M-1];
                        dneg_d  = din0[N-1];
                        cnt_d   = CW'(N);
                        state_d = ITER;
                    end
                end
                ITER: begin
                    prem_d = trial[M+1] ? shifted[M:0] : trial[M:0];
                    dvd_d  = {dvd_q[N-2:0], ~trial[M+1]};
                    cnt_d  = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = FIX;
                    end
                end
                FIX: begin
                    vld_d   = 1'b1;
                    state_d = IDLE;
                    if (dz) begin
                        quot_d = dneg_q ? QMIN : QMAX;
                        rem_d  = '0;
                        ovf_d  = 1'b0;
                        dbz_d  = 1'b1;
                    end else begin
                        dbz_d = 1'b0;
                        rem_d = dneg_q ? M'(-rmag) : M'(rmag);
                        if (ovf_hit) begin
                            quot_d = qneg_q ? QMIN : QMAX;
                            ovf_d  = 1'b1;
                        end else begin
                            quot_d = qneg_q ? dout_WIDTH'(-qmag) : dout_WIDTH'(qmag);
                            ovf_d  = 1'b0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            prem_q  <= '0;
            qneg_q  <= 1'b0;
            dneg_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            prem_q  <= prem_d;
            qneg_q  <= qneg_d;
            dneg_q  <= dneg_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
            vld_q   <= vld_d;
        end
    end

    assign ready       = (state_q == IDLE);
    assign dout_vld    = vld_q;
    assign quot        = quot_q;
    assign rem         = rem_q;
    assign ovf         = ovf_q;
    assign div_by_zero = dbz_q;
endmodule

// File: doc/mpc_div_sdiv_28s_7s_21_seq.md
Name: mpc_div_sdiv_28s_7s_21_seq

Overview:
Sequential signed divider for the MPC datapath. It is the inverse operator of the 21s×7s→28 pipelined multipliers: it takes a 28-bit product-domain value and a 7-bit signed divisor, and returns a 21-bit quotient and a 7-bit remainder. It is a radix-2 restoring divider with a start/ready/valid handshake and fixed latency. It is gated by the same clk/reset/ce scheme as the multiplier cores and is used in the solver's normalisation step.

Parameters:
din0_WIDTH, 28, dividend width (signed)
din1_WIDTH, 7, divisor width (signed); also the remainder width
dout_WIDTH, 21, quotient width (signed)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
ce  input  1  clock enable; all state advances only when ce=1
start  input  1  request; accepted on an edge where ce=1, start=1, ready=1
din0  input  din0_WIDTH  dividend, sampled at acceptance
din1  input  din1_WIDTH  divisor, sampled at acceptance
ready  output  1  block idle and able to accept start
dout_vld  output  1  result valid, one ce-cycle pulse
quot  output  dout_WIDTH  signed quotient
rem  output  din1_WIDTH  signed remainder
ovf  output  1  quotient saturated, valid with dout_vld
div_by_zero  output  1  divisor was zero, valid with dout_vld

Behaviour:
- Interface: one clock clk; synchronous active-high reset named reset.
- Reset: state=IDLE, ready=1, dout_vld=0, quot=0, rem=0, ovf=0, div_by_zero=0. Reset wins over ce. Reset mid-operation aborts the operation with no dout_vld.
- ce=0: all registers hold, including dout_vld, and start is ignored.
- FSM (every transition requires ce=1):
  - IDLE: on accept, register |din0| as an N-bit unsigned value (N=din0_WIDTH) and |din1| as an M-bit unsigned value. −2^27 and −64 are representable. Register the sign of the quotient and the sign of the dividend, set cnt=N, clear dout_vld, drop ready, go to ITER. Without an accept, dout_vld clears.
  - ITER: one restoring step per cycle. The partial remainder register is M+1 bits: shift in the next dividend MSB, trial-subtract the divisor magnitude, keep the result if non-negative, and shift the quotient bit into the magnitude. Decrement cnt; when cnt reaches 1, go to FIX.
  - FIX: apply signs, saturation and flags, register the outputs, set dout_vld=1 and ready=1, go to IDLE.
- Latency: dout_vld is high in the cycle after the (N+1)th ce-edge following the accept edge, i.e. 29 ce-cycles at the defaults. Fixed for all operands, including divide-by-zero.
- Back-to-back: start may be accepted in the cycle dout_vld=1. The new operation starts and dout_vld drops after that edge. quot, rem and flags hold until the next FIX.
- Arithmetic: the quotient truncates toward zero; the remainder takes the sign of the dividend; |rem| < |divisor|.
- Overflow: a positive magnitude above 2^(dout_WIDTH−1)−1 gives quot=+max. A negative magnitude above 2^(dout_WIDTH−1) gives quot=−min. In both cases ovf=1 and rem is the true remainder.
- Divide by zero: div_by_zero=1, ovf=0, rem=0. quot=+max if din0≥0, otherwise −min.

Optional Feature:
MPC_DIV_ROUND_EN
- Defined: FIX rounds half away from zero. If 2·|rem| ≥ |divisor|, the magnitude is incremented before sign and saturation are applied. The remainder is then reported as din0 − quot·din1 and may have the opposite sign. Saturation is checked on the incremented magnitude. Latency is unchanged.
- Undefined: truncation only; no rounding logic is present.

Test Plan:
1. Reset, then start with din0=1000, din1=7. Expect dout_vld exactly 29 cycles later, quot=142, rem=6, ovf=0, ready=1. With ROUND_EN: quot=143, rem=−1.
2. din0=−1000, din1=7 → quot=−142, rem=−6. With ROUND_EN: quot=−143, rem=1.
3. din0=−134217728, din1=−64 (true quotient 2^21) → quot=1048575, ovf=1, rem=0. Then din0=−1048576, din1=1 → quot=−1048576, ovf=0.
4. din0=5, din1=0 → quot=1048575, rem=0, div_by_zero=1, 29-cycle latency. din0=−5, din1=0 → quot=−1048576.
5. Hold ce low for 10 cycles mid-ITER → dout_vld appears 39 cycles after the accept and the result is unchanged. Assert reset at cycle 15 of an operation → no dout_vld, and ready=1 after the reset edge.
6. Assert start (100/−7) in the same cycle as dout_vld of op 1 (1000/7) → op-1 outputs hold until op 2 completes 29 cycles later with quot=−14, rem=2. start while ready=0 is ignored.
